// File: rtl/lsu_ahbl_bridge_pkg.sv
// Shared AHB-Lite encodings, bridge FSM states and the bridge's internal register bundles.
package system_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic {IDLE, DPH} lsu_bridge_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] wdata;
  } lsu_dph_t;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } lsu_rsp_t;
endpackage

// File: rtl/lsu_ahbl_bridge_if.sv
// AHB-Lite single-master link between the LSU bridge and the interconnect.
interface ahblite_interconnection #(parameter int HADDR_W = 32);
  logic               hsel;
  logic [HADDR_W-1:0] haddr;
  logic [2:0]         hsize;
  logic               hwrite;
  logic [1:0]         htrans;
  logic [31:0]        hwdata;
  logic [31:0]        hrdata;
  logic               hready;
  logic               hresp;

  modport ahblite_master (
    output hsel, haddr, hsize, hwrite, htrans, hwdata,
    input  hrdata, hready, hresp
  );

  modport ahblite_slave (
    input  hsel, haddr, hsize, hwrite, htrans, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/lsu_ahbl_bridge_be_decode.sv
// Byte-enable to AHB transfer size / low address decode; flags non-naturally-aligned patterns.
module lsu_be_decode
  import system_pkg::*;
(
  input  logic [3:0] be,
  input  logic [1:0] addr,
  output logic [2:0] hsize,
  output logic [1:0] haddr,
  output logic       illegal
);
  // The core presents a word base; the lane offset is fully implied by be.
  logic unused_addr;
  assign unused_addr = ^addr;

  always_comb begin
    hsize   = HSIZE_WORD;
    haddr   = 2'b00;
    illegal = 1'b0;
    case (be)
      4'b1111: hsize = HSIZE_WORD;
      4'b0011: hsize = HSIZE_HALF;
      4'b1100: begin hsize = HSIZE_HALF; haddr = 2'b10; end
      4'b0001: hsize = HSIZE_BYTE;
      4'b0010: begin hsize = HSIZE_BYTE; haddr = 2'b01; end
      4'b0100: begin hsize = HSIZE_BYTE; haddr = 2'b10; end
      4'b1000: begin hsize = HSIZE_BYTE; haddr = 2'b11; end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/lsu_ahbl_bridge.sv
// Core load/store port to pipelined single AHB-Lite transfers; in-order registered responses.
module lsu_ahbl_bridge
  import system_pkg::*;
#(
  parameter int HADDR_W = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               data_req_i,
  output logic               data_gnt_o,
  input  logic               data_we_i,
  input  logic [3:0]         data_be_i,
  input  logic [HADDR_W-1:0] data_addr_i,
  input  logic [31:0]        data_wdata_i,
  output logic               data_rvalid_o,
  output logic [31:0]        data_rdata_o,
  output logic               data_err_o,
  ahblite_interconnection.ahblite_master master0
);
  lsu_bridge_state_e state, state_nxt;
  logic [2:0] dec_size;
  logic [1:0] dec_lo;
  logic       illegal;
  logic       gnt_legal, gnt_ill, done;
  lsu_dph_t   dph_q;
  lsu_rsp_t   rsp_q;

  lsu_be_decode u_dec (
    .be      (data_be_i),
    .addr    (data_addr_i[1:0]),
    .hsize   (dec_size),
    .haddr   (dec_lo),
    .illegal (illegal)
  );

  always_comb begin
    gnt_legal = 1'b0;
    gnt_ill   = 1'b0;
    done      = (state == DPH) && master0.hready;
    if (rstn && data_req_i) begin
      // Illegal requests wait for an empty data phase so their error stays in order.
      if (!illegal) gnt_legal = (state == IDLE) || master0.hready;
      else          gnt_ill   = (state == IDLE);
    end
    state_nxt = state;
    if (gnt_legal)           state_nxt = DPH;
    else if (master0.hready) state_nxt = IDLE;
  end

  always_comb begin
    master0.hsel   = gnt_legal;
    master0.htrans = gnt_legal ? HTRANS_NONSEQ : HTRANS_IDLE;
    master0.hwrite = gnt_legal & data_we_i;
    master0.haddr  = '0;
    master0.hsize  = HSIZE_WORD;
    // Track the held request so the address is stable across wait states.
    if (rstn && data_req_i && !illegal) begin
      master0.haddr = {data_addr_i[HADDR_W-1:2], dec_lo};
      master0.hsize = dec_size;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      dph_q <= '0;
      rsp_q <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_legal) dph_q <= '{we: data_we_i, wdata: data_wdata_i};
      rsp_q.valid <= done | gnt_ill;
      if (gnt_ill) begin
        rsp_q.err <= 1'b1;
      end else if (done) begin
        rsp_q.err <= master0.hresp;
        if (!dph_q.we) rsp_q.rdata <= master0.hrdata;
      end
    end
  end

  assign master0.hwdata = dph_q.wdata;
  assign data_gnt_o     = gnt_legal | gnt_ill;
  assign data_rvalid_o  = rsp_q.valid;
  assign data_rdata_o   = rsp_q.rdata;
  assign data_err_o     = rsp_q.err;
endmodule

// File: doc/lsu_ahbl_bridge.md
# lsu_ahbl_bridge

Converts the core's load/store data interface (req/gnt/rvalid, byte enables) into single AHB-Lite master transfers that feed the interconnect and, through it, the data SRAM slave. Address and data phases are pipelined, so one new transfer can be granted while the previous one is still in its data phase. Responses return to the core in order, registered, with bus errors and illegal byte-enable patterns both reported as `data_err_o`.

## Interface
- `HADDR_W`, 32, width of `data_addr_i` and AHB `haddr`.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `data_req_i`  in  1  core request valid.
- `data_gnt_o`  out  1  request accepted this cycle (combinational).
- `data_we_i`  in  1  1 = store, 0 = load.
- `data_be_i`  in  4  byte enables.
- `data_addr_i`  in  HADDR_W  byte address.
- `data_wdata_i`  in  32  store data, already lane-aligned by the core.
- `data_rvalid_o`  out  1  response valid (registered).
- `data_rdata_o`  out  32  load data (registered).
- `data_err_o`  out  1  error flag, qualified by `data_rvalid_o`.
- `master0`  `ahblite_interconnection.ahblite_master`  —  carries `hsel`, `haddr`, `hsize`, `hwrite`, `htrans`, `hwdata` (out) and `hrdata`, `hready`, `hresp` (in).

## Operation
- **Byte-enable decode:**
  - `1111` → word, `hsize=010`, `haddr[1:0]=00`.
  - `0011` → half, `hsize=001`, `haddr[1:0]=00`.
  - `1100` → half, `hsize=001`, `haddr[1:0]=10`.
  - One-hot pattern → byte, `hsize=000`, `haddr[1:0]` = index of the set bit.
  - Any other pattern is illegal.
- **States** (two-state FSM):
  - `IDLE`: no data phase pending.
  - `DPH`: a data phase is pending.
  - The "data phase pending" flag is a flop set by any legal grant. It clears when `hready=1` with no new grant in that cycle.
- **Address phase:**
  - Driven combinationally from core inputs in the grant cycle: `hsel=1`, `htrans=NONSEQ` (`2'b10`), `haddr` as decoded, `hsize`, `hwrite=data_we_i`.
  - Otherwise `htrans=IDLE` (`2'b00`), `hsel=0`, `hwrite=0`.
- **Grant rule:**
  - Legal request: `data_gnt_o = data_req_i && (state==IDLE || hready)`.
  - Illegal request: granted only in `IDLE`, so that no bus response is outstanding. No bus transfer is issued (`htrans` stays IDLE). An error response follows one cycle later.
- **Data phase:**
  - The `we` and `wdata` captured at grant are held in registers.
  - `hwdata` is driven from the registered wdata throughout `DPH`.
  - Completion is the first cycle with `hready=1` while in `DPH`.
- **Response (registered on completion):**
  - `data_rvalid_o=1` for exactly one cycle.
  - `data_rdata_o = hrdata` for loads; unchanged for stores.
  - `data_err_o = hresp`.
- **Wait states:** while `hready=0` in `DPH`:
  - `data_gnt_o=0`.
  - The pending address-phase signals stay stable, per AHB rules.
  - The data-phase registers are held.

## Timing
- **Reset values:**
  - `data_gnt_o=0` while `rstn` is low.
  - `data_rvalid_o=0`, `data_err_o=0`, `data_rdata_o=0`.
  - `htrans=IDLE`, `hsel=0`, `hwrite=0`, `hsize=010`, `haddr=0`, `hwdata=0`.
  - State `IDLE`.
- **Reset asserted mid-transfer:** all of the above apply immediately. The pending transfer is dropped and no response is produced after reset.
- **Latency with a zero-wait slave:**
  - Cycle 0: grant plus address phase.
  - Cycle 1: data phase.
  - Cycle 2: `data_rvalid_o`.
- **Back-to-back throughput:** one transfer per cycle with `hready=1`. The response of transfer N and the grant of transfer N+2 may coincide.
- **Wait states:** each cycle of `hready=0` in `DPH` delays the response by one cycle.
- **Illegal byte enable:** grant in cycle 0, `rvalid=1` and `err=1` in cycle 1, no bus activity.
- **Error responses:**
  - `hresp=1` is sampled only on the completing cycle.
  - The error is reported on that transfer only.
  - A transfer already granted behind it still completes normally; there is no abort.

## Structure
- `system_pkg` holds:
  - `HTRANS_IDLE`, `HTRANS_NONSEQ`.
  - `HSIZE_BYTE`, `HSIZE_HALF`, `HSIZE_WORD`.
  - `lsu_bridge_state_e` (`IDLE`, `DPH`).
- Sub-module `lsu_be_decode` (combinational):
  - Inputs: `be`, `addr[1:0]` (word base).
  - Outputs: `hsize`, `haddr[1:0]`, `illegal`.
- Top-level block contents: FSM, data-phase registers, response registers, grant logic.

## Test plan
- **Word store then load:** store `be=1111`, addr `0x100`, wdata `0xDEADBEEF`, then load from `0x100` with a zero-wait slave → `htrans` NONSEQ/NONSEQ in consecutive cycles; `hwdata=0xDEADBEEF` in cycle 1; load `rvalid` in cycle 3 with `rdata=0xDEADBEEF`, `err=0`.
- **Byte and half sizes:** load `be=0100`, addr `0x200` → `haddr=0x202`, `hsize=000`. Load `be=1100` → `haddr=0x202`, `hsize=001`.
- **Illegal byte enable:** request `be=0101` → granted only when idle; `htrans` stays IDLE; next cycle `rvalid=1`, `err=1`.
- **Wait states:** `hready` held low for 3 cycles during the data phase with a second request pending → `gnt` low for 3 cycles; address phase stable; response at cycle 5; second grant on the `hready` rising cycle.
- **Bus error:** `hresp=1` on completion of a store → `rvalid=1`, `err=1`; the following load completes with `err=0`.
- **Reset mid-data-phase:** `rstn` dropped while in `DPH` → all outputs at reset values immediately; no `rvalid` after release.
